// File: rtl/pc_fetch_gen_pkg.sv
// pc_gen_pkg -- shared definitions for the fetch PC generator.
//   PC_W     : width of every program counter value.
//   PC_INC   : sequential fetch increment (one 32-bit instruction).
//   state_e  : PC generator FSM states.
//   prio_e   : redirect source priority. The encoding is ordered, so a
//              numeric compare gives the winner (MEM is the oldest
//              instruction and the most authoritative).
//   align_pc : clears the two low bits of a redirect target.
package pc_gen_pkg;

    localparam int              PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD      = 2'd1,
        ST_HOLD_PEND = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PRIO_NONE = 2'd0,
        PRIO_ID   = 2'd1,
        PRIO_EX   = 2'd2,
        PRIO_MEM  = 2'd3
    } prio_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] target);
        return {target[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if -- stall/redirect inputs and PC outputs of the fetch PC
// generator.
//   master : pipeline side; drives stall and redirects, observes the PC.
//   slave  : the PC generator itself.
interface pc_fetch_gen_if;
    import pc_gen_pkg::*;

    logic            stall_i;
    logic            redir_id_valid_i;
    logic [PC_W-1:0] redir_id_target_i;
    logic            redir_ex_valid_i;
    logic [PC_W-1:0] redir_ex_target_i;
    logic            redir_mem_valid_i;
    logic [PC_W-1:0] redir_mem_target_i;
    logic [PC_W-1:0] pc_o;
    logic [PC_W-1:0] pc_prev_o;
    logic            flush_o;
    logic            misalign_o;
    logic            stall_overflow_o;

    modport master (
        output stall_i,
        output redir_id_valid_i, redir_id_target_i,
        output redir_ex_valid_i, redir_ex_target_i,
        output redir_mem_valid_i, redir_mem_target_i,
        input  pc_o, pc_prev_o, flush_o, misalign_o, stall_overflow_o
    );

    modport slave (
        input  stall_i,
        input  redir_id_valid_i, redir_id_target_i,
        input  redir_ex_valid_i, redir_ex_target_i,
        input  redir_mem_valid_i, redir_mem_target_i,
        output pc_o, pc_prev_o, flush_o, misalign_o, stall_overflow_o
    );

endinterface

// File: rtl/pc_fetch_gen_arb.sv
// pc_redirect_arb -- combinational redirect selector.
//   *_valid_i / *_target_i : ID, EX and MEM redirect requests.
//   target_o               : raw (unaligned) target of the winner.
//   prio_o                 : winning level, PRIO_NONE when nothing is valid.
// The oldest instruction (MEM) wins; losers are simply dropped.
module pc_redirect_arb
    import pc_gen_pkg::*;
(
    input  logic            id_valid_i,
    input  logic [PC_W-1:0] id_target_i,
    input  logic            ex_valid_i,
    input  logic [PC_W-1:0] ex_target_i,
    input  logic            mem_valid_i,
    input  logic [PC_W-1:0] mem_target_i,
    output logic [PC_W-1:0] target_o,
    output prio_e           prio_o
);

    always_comb begin
        target_o = '0;
        prio_o   = PRIO_NONE;
        if (mem_valid_i) begin
            target_o = mem_target_i;
            prio_o   = PRIO_MEM;
        end else if (ex_valid_i) begin
            target_o = ex_target_i;
            prio_o   = PRIO_EX;
        end else if (id_valid_i) begin
            target_o = id_target_i;
            prio_o   = PRIO_ID;
        end
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen -- fetch program counter generator.
//   clk   : clock, rising edge.
//   reset : synchronous, active-low.
//   bus   : pc_fetch_gen_if.slave -- stall_i, three redirect valid/target
//           pairs in; pc_o, pc_prev_o, flush_o, misalign_o and the sticky
//           stall_overflow_o out. All outputs come straight from flops.
// Redirects seen during a stall are parked in a one-entry pending buffer and
// applied (with their flush/misalign pulse) in the release cycle.
module pc_fetch_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 3
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_gen_if.slave  bus
);

    localparam int               CNT_W     = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] STALL_SAT = CNT_W'(MAX_STALL + 1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_prev_q, pc_prev_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]   pend_target_q, pend_target_d;
    prio_e             pend_prio_q, pend_prio_d;
    logic              pend_mis_q, pend_mis_d;

    logic [PC_W-1:0]   arb_target;
    prio_e             arb_prio;
    logic              pend_valid;

    pc_redirect_arb u_arb (
        .id_valid_i   (bus.redir_id_valid_i),
        .id_target_i  (bus.redir_id_target_i),
        .ex_valid_i   (bus.redir_ex_valid_i),
        .ex_target_i  (bus.redir_ex_target_i),
        .mem_valid_i  (bus.redir_mem_valid_i),
        .mem_target_i (bus.redir_mem_target_i),
        .target_o     (arb_target),
        .prio_o       (arb_prio)
    );

    assign pend_valid = (state_q == ST_HOLD_PEND);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_prev_d     = pc_prev_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        overflow_d    = overflow_q;
        stall_cnt_d   = stall_cnt_q;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;
        pend_mis_d    = pend_mis_q;

        if (bus.stall_i) begin
            if (stall_cnt_q != STALL_SAT) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            // Equal priority overwrites: the younger request of the same
            // level is the more recent redirect decision.
            if (arb_prio != PRIO_NONE && (!pend_valid || arb_prio >= pend_prio_q)) begin
                pend_target_d = align_pc(arb_target);
                pend_prio_d   = arb_prio;
                pend_mis_d    = |arb_target[1:0];
            end
            state_d = (pend_valid || arb_prio != PRIO_NONE) ? ST_HOLD_PEND : ST_HOLD;
        end else begin
            stall_cnt_d   = '0;
            state_d       = ST_RUN;
            pend_target_d = '0;
            pend_prio_d   = PRIO_NONE;
            pend_mis_d    = 1'b0;
            // Pending entry only beats a current request of strictly lower
            // priority; ties go to the current request.
            if (pend_valid && pend_prio_q > arb_prio) begin
                pc_d       = pend_target_q;
                flush_d    = 1'b1;
                misalign_d = pend_mis_q;
            end else if (arb_prio != PRIO_NONE) begin
                pc_d       = align_pc(arb_target);
                flush_d    = 1'b1;
                misalign_d = |arb_target[1:0];
            end else begin
                pc_d = pc_q + PC_INC;
            end
        end

        if (stall_cnt_d == STALL_SAT) begin
            overflow_d = 1'b1;
        end
        if (pc_d != pc_q) begin
            pc_prev_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pc_prev_q     <= RESET_PC;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            overflow_q    <= 1'b0;
            stall_cnt_q   <= '0;
            pend_target_q <= '0;
            pend_prio_q   <= PRIO_NONE;
            pend_mis_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_prev_q     <= pc_prev_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            overflow_q    <= overflow_d;
            stall_cnt_q   <= stall_cnt_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
            pend_mis_q    <= pend_mis_d;
        end
    end

    assign bus.pc_o             = pc_q;
    assign bus.pc_prev_o        = pc_prev_q;
    assign bus.flush_o          = flush_q;
    assign bus.misalign_o       = misalign_q;
    assign bus.stall_overflow_o = overflow_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen -- directed scenarios for pc_fetch_gen. Each scenario task
// builds a per-cycle stimulus table with hand-derived expected outputs; the
// expectation is pushed to a scoreboard queue when the cycle is driven and
// popped when the registered outputs are sampled after the clock edge.
module tb_pc_fetch_gen;
    import pc_gen_pkg::*;

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        idv;
        logic [31:0] idt;
        logic        exv;
        logic [31:0] ext;
        logic        memv;
        logic [31:0] memt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] prev;
        logic        flush;
        logic        mis;
        logic        ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    pc_fetch_gen_if bus();

    pc_fetch_gen #(
        .RESET_PC  (32'h0000_0000),
        .MAX_STALL (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic st,
                                 input logic iv, input logic [31:0] it,
                                 input logic ev, input logic [31:0] et,
                                 input logic mv, input logic [31:0] mt);
        stim_t s;
        s = '{rst_n: r, stall: st, idv: iv, idt: it, exv: ev, ext: et, memv: mv, memt: mt};
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, input logic [31:0] prev,
                                input logic fl, input logic mi, input logic ov);
        exp_t e;
        e = '{pc: pc, prev: prev, flush: fl, mis: mi, ovf: ov};
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g = '{pc: bus.pc_o, prev: bus.pc_prev_o, flush: bus.flush_o,
              mis: bus.misalign_o, ovf: bus.stall_overflow_o};
        return g;
    endfunction

    function automatic string fmt(input exp_t v);
        return $sformatf("pc=%h prev=%h flush=%b mis=%b ovf=%b", v.pc, v.prev, v.flush, v.mis, v.ovf);
    endfunction

    task automatic step(input stim_t s);
        reset                  = s.rst_n;
        bus.stall_i            = s.stall;
        bus.redir_id_valid_i   = s.idv;
        bus.redir_id_target_i  = s.idt;
        bus.redir_ex_valid_i   = s.exv;
        bus.redir_ex_target_i  = s.ext;
        bus.redir_mem_valid_i  = s.memv;
        bus.redir_mem_target_i = s.memt;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        st.push_back(mk(0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h303)); xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h303)); xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));                   xp.push_back(ex(4, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL reset[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_free_run();
        exp_t got, e;
        apply_reset();
        n_cmp++;
        got = sample();
        if (got !== ex(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("[TB] FAIL free_run_start: got %s expected %s", fmt(got), fmt(ex(0, 0, 0, 0, 0)));
        end
        for (int i = 1; i <= 5; i++) begin
            sb.push_back(ex(32'(4 * i), 32'(4 * (i - 1)), 0, 0, 0));
            step(mk(1, 0, 0, 0, 0, 0, 0, 0));
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL free_run[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_simultaneous();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        apply_reset();
        st.push_back(mk(1, 0, 1, 32'h100, 1, 32'h200, 1, 32'h303)); xp.push_back(ex(32'h300, 0, 1, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));                   xp.push_back(ex(32'h304, 32'h300, 0, 0, 0));
        st.push_back(mk(1, 0, 1, 32'h123, 0, 0, 0, 0));             xp.push_back(ex(32'h120, 32'h304, 1, 1, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 32'h840, 0, 0));             xp.push_back(ex(32'h840, 32'h120, 1, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL simultaneous[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_stall_redirect();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        apply_reset();
        st.push_back(mk(1, 1, 0, 0, 1, 32'h400, 0, 0)); xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h400, 0, 1, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h404, 32'h400, 0, 0, 0));
        // misaligned pending target: pulse appears at release, not latch
        st.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'h202)); xp.push_back(ex(32'h404, 32'h400, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h200, 32'h404, 1, 1, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL stall_redirect[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_pending_priority();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        apply_reset();
        // lower-priority ID must not overwrite pending MEM
        st.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'h500)); xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 1, 1, 32'h600, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h500, 0, 1, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h504, 32'h500, 0, 0, 0));
        // pending ID loses to current EX at release
        st.push_back(mk(1, 1, 1, 32'h700, 0, 0, 0, 0)); xp.push_back(ex(32'h504, 32'h500, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 32'h800, 0, 0)); xp.push_back(ex(32'h800, 32'h504, 1, 0, 0));
        // tie at release goes to the current request
        st.push_back(mk(1, 1, 0, 0, 1, 32'h900, 0, 0)); xp.push_back(ex(32'h800, 32'h504, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 1, 32'hA00, 0, 0)); xp.push_back(ex(32'hA00, 32'h800, 1, 0, 0));
        // pending MEM beats current ID at release
        st.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'hB00)); xp.push_back(ex(32'hA00, 32'h800, 0, 0, 0));
        st.push_back(mk(1, 0, 1, 32'hC00, 0, 0, 0, 0)); xp.push_back(ex(32'hB00, 32'hA00, 1, 0, 0));
        // equal priority during stall overwrites
        st.push_back(mk(1, 1, 1, 32'h600, 0, 0, 0, 0)); xp.push_back(ex(32'hB00, 32'hA00, 0, 0, 0));
        st.push_back(mk(1, 1, 1, 32'h610, 0, 0, 0, 0)); xp.push_back(ex(32'hB00, 32'hA00, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h610, 32'hB00, 1, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));       xp.push_back(ex(32'h614, 32'h610, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL pending_priority[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        apply_reset();
        st.push_back(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0)); xp.push_back(ex(32'hFFFF_FFFC, 0, 1, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h0, 32'hFFFF_FFFC, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));             xp.push_back(ex(32'h4, 32'h0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL wrap[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_watchdog();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  got, e;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0, 0, 0));
        end
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(4, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(4, 0, 0, 0, 0));
        end
        st.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(4, 0, 0, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(8, 4, 0, 0, 1));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(12, 8, 0, 0, 1));
        // reset mid-stall drops the pending redirect and the sticky flag
        st.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'h700)); xp.push_back(ex(12, 8, 0, 0, 1));
        st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(0, 0, 0, 0, 0));
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));     xp.push_back(ex(4, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            sb.push_back(xp[i]);
            step(st[i]);
            got = sample();
            e = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL watchdog[%0d]: got %s expected %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        test_reset();
        test_free_run();
        test_simultaneous();
        test_stall_redirect();
        test_pending_priority();
        test_wrap();
        test_watchdog();
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
